uart_tx_framer: RTL and testbench
=================================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
- REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame, legal range 5-9.
- REQ-002 Parameter PARITY_EN, default 0: 1 inserts a parity bit after the data bits; 0 omits it.
- REQ-003 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
- REQ-004 Parameter STOP_BITS, default 1, number of stop bits, legal values 1 or 2.
- REQ-005 Parameter MSB_FIRST, default 0: 0 sends data LSB first; 1 sends data MSB first.
- REQ-006 Derived constant FRAME_LEN SHALL equal 1 + DATA_BITS + PARITY_EN + STOP_BITS.
- REQ-007 clk  input  1  single clock; all state updates on its rising edge.
- REQ-008 reset  input  1  asynchronous, active-high reset.
- REQ-009 baud_tick  input  1  one-clk-wide enable marking each bit-period boundary.
- REQ-010 Load  input  1  start request; sampled on each clk edge.
- REQ-011 Data  input  DATA_BITS  payload; sampled only on an accepted Load.
- REQ-012 SDO  output  1  serial line output, registered, idle level 1.
- REQ-013 busy  output  1  high from the edge after an accepted Load until the frame completes.
- REQ-014 done  output  1  one-clk pulse at frame completion.

Function
- REQ-015 The block SHALL have two states. IDLE: busy=0. SHIFT: busy=1.
- REQ-016 In IDLE, Load=1 SHALL be accepted. On that edge the block SHALL move to SHIFT, capture the frame into a FRAME_LEN-bit register, and clear a bit counter to 0.
- REQ-017 The frame order SHALL be: start bit 0, then data (LSB or MSB first per MSB_FIRST), then parity if enabled, then STOP_BITS ones.
- REQ-018 The parity bit SHALL be the XOR of all Data bits. When PARITY_ODD=1 it SHALL be that XOR inverted.
- REQ-019 On each baud_tick in SHIFT while counter < FRAME_LEN:
  - SDO <= current frame-register LSB;
  - frame register shifts right with 1 filled at the MSB;
  - counter increments.
- REQ-020 On the baud_tick in SHIFT with counter == FRAME_LEN:
  - state returns to IDLE;
  - busy <= 0;
  - done <= 1 for exactly one clk;
  - SDO stays 1.
  This ensures the last stop bit is held for a full bit period.
- REQ-021 SDO SHALL hold its value on every clk without baud_tick. SDO SHALL be 1 throughout IDLE, including the cycles between an accepted Load and the first baud_tick.
- REQ-022 Load during SHIFT SHALL be ignored. The in-flight frame and the captured Data SHALL be unaffected.
- REQ-023 Load and baud_tick asserted together in IDLE: Load SHALL be accepted, and that tick SHALL NOT drive a bit. The first bit goes out on the next baud_tick.
- REQ-024 Load asserted in the same cycle as the completing tick (REQ-020) SHALL be ignored. A new frame needs Load on a later cycle with busy=0.
- REQ-025 Minimum inter-frame idle time SHALL be one clk after done, so back-to-back frames are possible.
- REQ-026 The counter SHALL be sized to hold FRAME_LEN (ceil(log2(FRAME_LEN+1)) bits) and SHALL NOT wrap during a frame.
- REQ-027 baud_tick in IDLE SHALL have no effect.

Reset
- REQ-028 Asserting reset SHALL immediately, independent of clk, set:
  - state=IDLE, SDO=1, busy=0, done=0;
  - frame register all ones;
  - counter 0.
- REQ-029 Reset mid-frame SHALL abort the frame with no done pulse. SDO SHALL return to 1 without a clk edge.
- REQ-030 After reset deasserts, the first Load SHALL be accepted on the first rising clk edge.

Verification
- REQ-031 Default parameters, Data=8'hA5, Load then 10 ticks, 1 extra tick:
  - SDO sequence 0,1,0,1,0,0,1,0,1,1;
  - busy falls and done pulses on the 11th tick.
- REQ-032 PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, Data=8'h07:
  - SDO sequence 0,1,1,1,0,0,0,0,0,1,1,1 (parity=1);
  - PARITY_ODD=1 gives parity bit 0.
- REQ-033 MSB_FIRST=1, DATA_BITS=7, Data=7'h41: SDO sequence 0,1,0,0,0,0,0,1,1.
- REQ-034 Load=1 with Data=8'hFF during SHIFT of 8'h00:
  - the frame continues transmitting 8'h00;
  - busy stays high until the original completion.
- REQ-035 Reset asserted between clk edges after the 4th tick:
  - SDO=1 and busy=0 immediately;
  - no done pulse;
  - subsequent Load of 8'h3C transmits a correct full frame.
- REQ-036 Load coincident with baud_tick in IDLE:
  - SDO stays 1 that cycle;
  - start bit 0 appears on the next tick;
  - done for frame N followed by Load one clk later starts frame N+1 with no extra idle bit.

Source files
------------

// File: rtl/uart_tx_framer_if.sv
// uart_tx_framer_if: bundle between a UART transmit framer and its user.
//   baud_tick : bit-period boundary strobe, one clk wide
//   Load      : start request
//   Data      : payload, DATA_BITS wide
//   SDO       : serial line output (idle high)
//   busy      : frame in flight
//   done      : one-clk pulse at frame completion
// master drives the request side; slave is the framer.
interface uart_tx_framer_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 baud_tick;
    logic                 Load;
    logic [DATA_BITS-1:0] Data;
    logic                 SDO;
    logic                 busy;
    logic                 done;

    modport master (
        output baud_tick, Load, Data,
        input  SDO, busy, done
    );

    modport slave (
        input  baud_tick, Load, Data,
        output SDO, busy, done
    );
endinterface

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serialises one UART frame per accepted Load.
// Frame order: start 0, data (LSB or MSB first), optional parity, STOP_BITS ones.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : uart_tx_framer_if slave (baud_tick, Load, Data in; SDO, busy, done out)
module uart_tx_framer #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned MSB_FIRST  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_tx_framer_if.slave         bus
);
    localparam int unsigned FRAME_LEN = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic PAR_INV = (PARITY_ODD != 0);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_framer: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_framer: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                 state_q;
    logic                   sdo_q;
    logic                   busy_q;
    logic                   done_q;
    logic [FRAME_LEN-1:0]   frame_q;
    logic [CNT_W-1:0]       cnt_q;

    logic                   parity;
    logic [FRAME_LEN-1:0]   frame_load;

    assign parity = (^bus.Data) ^ PAR_INV;

    // Bit 0 of the frame register is the next bit on the line; stop bits
    // come for free from the all-ones default.
    always_comb begin
        frame_load    = '1;
        frame_load[0] = 1'b0;
        for (int i = 0; i < int'(DATA_BITS); i++) begin
            frame_load[i+1] = (MSB_FIRST != 0) ? bus.Data[int'(DATA_BITS)-1-i] : bus.Data[i];
        end
        if (PARITY_EN != 0) begin
            frame_load[DATA_BITS+1] = parity;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            sdo_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            frame_q <= '1;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A coincident baud_tick is deliberately not used here:
                    // the first bit waits for the next tick.
                    if (bus.Load) begin
                        state_q <= StShift;
                        busy_q  <= 1'b1;
                        frame_q <= frame_load;
                        cnt_q   <= '0;
                    end
                end
                StShift: begin
                    if (bus.baud_tick) begin
                        if (cnt_q < FRAME_LEN_C) begin
                            sdo_q   <= frame_q[0];
                            frame_q <= {1'b1, frame_q[FRAME_LEN-1:1]};
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end else begin
                            // Extra tick holds the last stop bit a full period.
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            sdo_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.SDO  = sdo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_uart_tx_framer.sv
module tb_uart_tx_framer;
    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       load_r [4];
    logic [8:0] data_r [4];
    logic       sdo_w  [4];
    logic       busy_w [4];
    logic       done_w [4];

    int q [4][$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_framer_if #(.DATA_BITS(8)) bus0 ();
    uart_tx_framer_if #(.DATA_BITS(8)) bus1 ();
    uart_tx_framer_if #(.DATA_BITS(7)) bus2 ();
    uart_tx_framer_if #(.DATA_BITS(8)) bus3 ();

    uart_tx_framer u0 (.clk(clk), .reset(reset), .bus(bus0));
    uart_tx_framer #(.PARITY_EN(1), .STOP_BITS(2)) u1 (.clk(clk), .reset(reset), .bus(bus1));
    uart_tx_framer #(.DATA_BITS(7), .MSB_FIRST(1)) u2 (.clk(clk), .reset(reset), .bus(bus2));
    uart_tx_framer #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u3
        (.clk(clk), .reset(reset), .bus(bus3));

    assign bus0.baud_tick = tick;
    assign bus1.baud_tick = tick;
    assign bus2.baud_tick = tick;
    assign bus3.baud_tick = tick;
    assign bus0.Load = load_r[0];
    assign bus1.Load = load_r[1];
    assign bus2.Load = load_r[2];
    assign bus3.Load = load_r[3];
    assign bus0.Data = data_r[0][7:0];
    assign bus1.Data = data_r[1][7:0];
    assign bus2.Data = data_r[2][6:0];
    assign bus3.Data = data_r[3][7:0];
    assign sdo_w[0] = bus0.SDO;
    assign sdo_w[1] = bus1.SDO;
    assign sdo_w[2] = bus2.SDO;
    assign sdo_w[3] = bus3.SDO;
    assign busy_w[0] = bus0.busy;
    assign busy_w[1] = bus1.busy;
    assign busy_w[2] = bus2.busy;
    assign busy_w[3] = bus3.busy;
    assign done_w[0] = bus0.done;
    assign done_w[1] = bus1.done;
    assign done_w[2] = bus2.done;
    assign done_w[3] = bus3.done;

    task automatic check(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Expected line bits written left to right in transmission order; 2 marks completion.
    task automatic push_frame(input int k, input int n, input logic [15:0] bits);
        for (int i = n - 1; i >= 0; i--) q[k].push_back(int'(bits[i]));
        q[k].push_back(2);
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic load_frame(input int k, input logic [8:0] d);
        @(negedge clk);
        load_r[k] = 1'b1;
        data_r[k] = d;
        @(negedge clk);
        load_r[k] = 1'b0;
    endtask

    // Monitor: every tick seen by a busy DUT either emits a bit or completes.
    initial begin
        logic t_s;
        logic b_s [4];
        int   e;
        forever begin
            @(negedge clk);
            #4;
            t_s = tick;
            for (int k = 0; k < 4; k++) b_s[k] = busy_w[k];
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (t_s === 1'b1 && b_s[k] === 1'b1) begin
                    if (q[k].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL dut%0d unexpected_tick_event: got sdo=%b done=%b required none",
                                 k, sdo_w[k], done_w[k]);
                    end else begin
                        e = q[k].pop_front();
                        if (e == 2) begin
                            check($sformatf("dut%0d done_pulse", k), done_w[k], 1'b1);
                            check($sformatf("dut%0d busy_fall", k), busy_w[k], 1'b0);
                            check($sformatf("dut%0d sdo_after_frame", k), sdo_w[k], 1'b1);
                        end else begin
                            check($sformatf("dut%0d sdo_bit", k), sdo_w[k], e[0]);
                            check($sformatf("dut%0d no_done_midframe", k), done_w[k], 1'b0);
                        end
                    end
                end else if (done_w[k] !== 1'b0) begin
                    total++;
                    bad++;
                    $display("FAIL dut%0d spurious_done: got %b required 0", k, done_w[k]);
                end
            end
        end
    end

    initial begin
        tick  = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            load_r[k] = 1'b0;
            data_r[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("dut%0d reset_sdo", k), sdo_w[k], 1'b1);
            check($sformatf("dut%0d reset_busy", k), busy_w[k], 1'b0);
            check($sformatf("dut%0d reset_done", k), done_w[k], 1'b0);
        end

        // Load on the first edge after reset release; 0xA5 default frame.
        reset     = 1'b0;
        load_r[0] = 1'b1;
        data_r[0] = 9'h0A5;
        push_frame(0, 10, 16'b0101001011);
        @(negedge clk);
        load_r[0] = 1'b0;
        check("busy_after_first_load", busy_w[0], 1'b1);
        check("sdo_idle_before_tick", sdo_w[0], 1'b1);
        tick_n(11);
        check("busy_low_after_a5", busy_w[0], 1'b0);

        // Parity even/odd with two stop bits, and 7-bit MSB-first.
        @(negedge clk);
        load_r[1] = 1'b1; data_r[1] = 9'h007;
        load_r[2] = 1'b1; data_r[2] = 9'h041;
        load_r[3] = 1'b1; data_r[3] = 9'h007;
        push_frame(1, 12, 16'b011100000111);
        push_frame(2, 9,  16'b010000011);
        push_frame(3, 12, 16'b011100000011);
        @(negedge clk);
        load_r[1] = 1'b0;
        load_r[2] = 1'b0;
        load_r[3] = 1'b0;
        tick_n(13);
        check("idle_ticks_sdo", sdo_w[0], 1'b1);
        check("idle_ticks_busy", busy_w[0], 1'b0);

        // Load coincident with a tick in idle: tick sends nothing.
        @(negedge clk);
        load_r[0] = 1'b1; data_r[0] = 9'h05A; tick = 1'b1;
        push_frame(0, 10, 16'b0010110101);
        @(negedge clk);
        load_r[0] = 1'b0; tick = 1'b0;
        check("load_tick_busy", busy_w[0], 1'b1);
        check("load_tick_sdo_high", sdo_w[0], 1'b1);
        tick_n(10);
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        // Back-to-back: Load in the done cycle.
        load_r[0] = 1'b1; data_r[0] = 9'h0C3;
        push_frame(0, 10, 16'b0110000111);
        @(negedge clk);
        load_r[0] = 1'b0;
        check("back_to_back_busy", busy_w[0], 1'b1);
        tick_n(10);
        // Load together with the completing tick is ignored.
        @(negedge clk);
        tick = 1'b1; load_r[0] = 1'b1; data_r[0] = 9'h0FF;
        @(negedge clk);
        tick = 1'b0; load_r[0] = 1'b0;
        check("load_at_completion_busy", busy_w[0], 1'b0);
        @(negedge clk);
        check("load_at_completion_stays_idle", busy_w[0], 1'b0);
        check("load_at_completion_sdo", sdo_w[0], 1'b1);

        // Load of 0xFF while 0x00 is in flight is ignored.
        load_frame(0, 9'h000);
        push_frame(0, 10, 16'b0000000001);
        tick_n(3);
        @(negedge clk);
        load_r[0] = 1'b1; data_r[0] = 9'h0FF;
        @(negedge clk);
        load_r[0] = 1'b0;
        check("load_in_shift_busy", busy_w[0], 1'b1);
        tick_n(7);
        check("busy_until_completion", busy_w[0], 1'b1);
        tick_n(1);

        // Asynchronous reset mid-frame after the 4th tick.
        load_frame(0, 9'h000);
        push_frame(0, 10, 16'b0000000001);
        tick_n(4);
        check("sdo_low_before_reset", sdo_w[0], 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async_reset_sdo", sdo_w[0], 1'b1);
        check("async_reset_busy", busy_w[0], 1'b0);
        check("async_reset_done", done_w[0], 1'b0);
        q[0].delete();
        @(negedge clk) reset = 1'b0;
        tick_n(2);
        load_frame(0, 9'h03C);
        push_frame(0, 10, 16'b0001111001);
        tick_n(11);

        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (q[k].size() != 0) begin
                bad++;
                $display("FAIL dut%0d scoreboard_drained: got %0d pending required 0",
                         k, q[k].size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
